// File: rtl/multicycle_control_fsm_pkg.sv
// =============================================================================
// Module      : multicycle_control_fsm_pkg
// Description : Shared state and control-field encodings for the multicycle FSM.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] C_ALU_ADD    = 2'b00;
   localparam logic [1:0] C_ALU_SUB    = 2'b01;
   localparam logic [1:0] C_ALU_AND    = 2'b10;
   localparam logic [1:0] C_ALU_ORR    = 2'b11;

   localparam logic [1:0] C_RES_ALUOUT = 2'b00;
   localparam logic [1:0] C_RES_DATA   = 2'b01;
   localparam logic [1:0] C_RES_ALU    = 2'b10;

   localparam logic [1:0] C_SRCB_RM    = 2'b00;
   localparam logic [1:0] C_SRCB_IMM   = 2'b01;
   localparam logic [1:0] C_SRCB_FOUR  = 2'b10;

   localparam logic [1:0] C_OP_DP      = 2'b00;
   localparam logic [1:0] C_OP_MEM     = 2'b01;
   localparam logic [1:0] C_OP_BR      = 2'b10;

   localparam logic [3:0] C_CMD_ADD    = 4'b0100;
   localparam logic [3:0] C_CMD_SUB    = 4'b0010;
   localparam logic [3:0] C_CMD_AND    = 4'b0000;
   localparam logic [3:0] C_CMD_ORR    = 4'b1100;
   localparam logic [3:0] C_CMD_CMP    = 4'b1010;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_fsm_if.sv
// =============================================================================
// Module      : multicycle_control_fsm_if
// Description : Instruction fields in, datapath control strobes out.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface multicycle_control_fsm_if;

   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;

   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic [1:0] FlagW;
   logic       NoWrite;
   logic       NextPC;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;

   modport master (
      output Op, Funct, Rd,
      input  PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
   );

   modport slave (
      input  Op, Funct, Rd,
      output PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
   );

endinterface

`default_nettype wire

// File: rtl/alu_decoder.sv
// =============================================================================
// Module      : alu_decoder
// Description : Maps data-processing cmd/S bits to ALU operation and flag writes.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic       alu_op_i,
   input  logic [5:0] funct_i,
   output logic [1:0] alu_control_o,
   output logic [1:0] flag_w_o,
   output logic       no_write_o
);

   always_comb begin
      alu_control_o = C_ALU_ADD;
      flag_w_o      = 2'b00;
      no_write_o    = 1'b0;
      if (alu_op_i) begin
         case (funct_i[4:1])
            C_CMD_ADD: alu_control_o = C_ALU_ADD;
            C_CMD_SUB: alu_control_o = C_ALU_SUB;
            C_CMD_AND: alu_control_o = C_ALU_AND;
            C_CMD_ORR: alu_control_o = C_ALU_ORR;
            C_CMD_CMP: begin
               alu_control_o = C_ALU_SUB;
               no_write_o    = 1'b1;
            end
            default:   alu_control_o = C_ALU_ADD;
         endcase
         // C and V are only meaningful for arithmetic operations
         flag_w_o = {funct_i[0],
                     funct_i[0] & ((alu_control_o == C_ALU_ADD) ||
                                   (alu_control_o == C_ALU_SUB))};
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// =============================================================================
// Module      : multicycle_control_fsm
// Description : Moore control FSM for a multicycle ARM-subset processor.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   multicycle_control_fsm_if.slave bus
);

   state_t state_q;
   state_t state_d;

   logic       w_irwrite;
   logic       w_nextpc;
   logic       w_adrsrc;
   logic [1:0] w_resultsrc;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic       w_alu_op;
   logic       w_regw;
   logic       w_memw;
   logic       w_branch;

   logic [1:0] w_alu_control;
   logic [1:0] w_flag_w;
   logic       w_no_write;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               C_OP_MEM: state_d = S_MEMADR;
               C_OP_DP:  state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               C_OP_BR:  state_d = S_BRANCH;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      w_irwrite   = 1'b0;
      w_nextpc    = 1'b0;
      w_adrsrc    = 1'b0;
      w_resultsrc = C_RES_ALUOUT;
      w_alusrca   = 1'b0;
      w_alusrcb   = C_SRCB_RM;
      w_alu_op    = 1'b0;
      w_regw      = 1'b0;
      w_memw      = 1'b0;
      w_branch    = 1'b0;
      case (state_q)
         S_FETCH: begin
            w_irwrite   = 1'b1;
            w_nextpc    = 1'b1;
            w_alusrca   = 1'b1;
            w_alusrcb   = C_SRCB_FOUR;
            w_resultsrc = C_RES_ALU;
         end
         S_DECODE: begin
            w_alusrca   = 1'b1;
            w_alusrcb   = C_SRCB_FOUR;
            w_resultsrc = C_RES_ALU;
         end
         S_MEMADR:   w_alusrcb = C_SRCB_IMM;
         S_MEMREAD:  w_adrsrc  = 1'b1;
         S_MEMWB: begin
            w_resultsrc = C_RES_DATA;
            w_regw      = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrsrc = 1'b1;
            w_memw   = 1'b1;
         end
         S_EXECUTER: begin
            w_alusrcb = C_SRCB_RM;
            w_alu_op  = 1'b1;
         end
         S_EXECUTEI: begin
            w_alusrcb = C_SRCB_IMM;
            w_alu_op  = 1'b1;
         end
         S_ALUWB:    w_regw = 1'b1;
         S_BRANCH: begin
            w_alusrcb   = C_SRCB_IMM;
            w_resultsrc = C_RES_ALU;
            w_branch    = 1'b1;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (w_alu_op),
      .funct_i       (bus.Funct),
      .alu_control_o (w_alu_control),
      .flag_w_o      (w_flag_w),
      .no_write_o    (w_no_write)
   );

   // Architectural side effects are blocked combinationally while reset is held
   assign bus.RegW       = w_regw   & ~reset;
   assign bus.MemW       = w_memw   & ~reset;
   assign bus.IRWrite    = w_irwrite & ~reset;
   assign bus.NextPC     = w_nextpc & ~reset;
   assign bus.PCS        = (((bus.Rd == 4'hF) & w_regw) | w_branch) & ~reset;
   assign bus.AdrSrc     = w_adrsrc;
   assign bus.ResultSrc  = w_resultsrc;
   assign bus.ALUSrcA    = w_alusrca;
   assign bus.ALUSrcB    = w_alusrcb;
   assign bus.ALUControl = w_alu_control;
   assign bus.FlagW      = w_flag_w;
   assign bus.NoWrite    = w_no_write;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == C_OP_MEM, bus.Op == C_OP_BR};

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// =============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed per-cycle output checks against a queue of expected vectors.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

   typedef struct packed {
      logic       pcs;
      logic       regw;
      logic       memw;
      logic [1:0] flagw;
      logic       nowrite;
      logic       nextpc;
      logic       irwrite;
      logic       adrsrc;
      logic [1:0] resultsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluctl;
      logic [1:0] immsrc;
      logic [1:0] regsrc;
   } out_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   out_t exp_q[$];
   string tag_q[$];

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector; ImmSrc/RegSrc follow the instruction currently driven
   function automatic out_t mk(input logic irw, input logic npc, input logic adr,
                               input logic [1:0] rs, input logic asa, input logic [1:0] asb,
                               input logic [1:0] alc, input logic [1:0] flw, input logic nw,
                               input logic regw, input logic memw, input logic pcs);
      out_t e;
      e.pcs = pcs; e.regw = regw; e.memw = memw; e.flagw = flw; e.nowrite = nw;
      e.nextpc = npc; e.irwrite = irw; e.adrsrc = adr; e.resultsrc = rs;
      e.alusrca = asa; e.alusrcb = asb; e.aluctl = alc; e.immsrc = bus.Op;
      e.regsrc = {bus.Op == 2'b01, bus.Op == 2'b10};
      return e;
   endfunction

   task automatic push(input string tag, input out_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
      bus.Op = op; bus.Funct = funct; bus.Rd = rd;
   endtask

   // Called on a falling edge: compare the oldest expectation, then advance one cycle
   task automatic step();
      out_t  obs;
      out_t  e;
      string t;
      #1;
      obs = {bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.NoWrite, bus.NextPC,
             bus.IRWrite, bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
             bus.ALUControl, bus.ImmSrc, bus.RegSrc};
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%b required=%b", t, obs, e);
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   out_t e_fetch, e_decode;

   task automatic push_front_end(input string tag);
      e_fetch  = mk(1, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
      e_decode = mk(0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
      push({tag, "_fetch"}, e_fetch);
      push({tag, "_decode"}, e_decode);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive(2'b00, 6'b000000, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset held: FETCH outputs with the write strobes suppressed
      push("reset_fetch", mk(0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0));
      step();

      // ADD register, Rd=2
      reset = 1'b0;
      drive(2'b00, 6'b001000, 4'h2);
      push_front_end("add");
      push("add_executer", mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      push("add_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(4);

      // LDR
      drive(2'b01, 6'b011001, 4'h3);
      push_front_end("ldr");
      push("ldr_memadr",  mk(0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
      push("ldr_memread", mk(0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      push("ldr_memwb",   mk(0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(5);

      // STR: MemW one cycle only, then straight back to FETCH
      drive(2'b01, 6'b011000, 4'h4);
      push_front_end("str");
      push("str_memadr",   mk(0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
      push("str_memwrite", mk(0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
      run(4);

      // CMP immediate
      drive(2'b00, 6'b110101, 4'h0);
      push_front_end("cmp");
      push("cmp_executei", mk(0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b11, 1, 0, 0, 0));
      push("cmp_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(4);

      // ANDS register: NZ only
      drive(2'b00, 6'b000001, 4'h5);
      push_front_end("ands");
      push("ands_executer", mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0));
      push("ands_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(4);

      // ORR immediate, unknown cmd with S set falls back to ADD
      drive(2'b00, 6'b111000, 4'h6);
      push_front_end("orr");
      push("orr_executei", mk(0, 0, 0, 2'b00, 0, 2'b01, 2'b11, 2'b00, 0, 0, 0, 0));
      push("orr_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(4);
      drive(2'b00, 6'b000111, 4'h7);
      push_front_end("dflt");
      push("dflt_executer", mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0));
      push("dflt_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      run(4);

      // Branch
      drive(2'b10, 6'b000000, 4'h0);
      push_front_end("b");
      push("b_branch", mk(0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1));
      run(3);

      // Data-processing writing PC
      drive(2'b00, 6'b001000, 4'hF);
      push_front_end("addpc");
      push("addpc_executer", mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      push("addpc_aluwb",    mk(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1));
      run(4);

      // Op=11 is a two-cycle no-op
      drive(2'b11, 6'b000000, 4'h0);
      push_front_end("op11");
      run(2);

      // Reset arriving in MEMWRITE
      drive(2'b01, 6'b011000, 4'h1);
      push_front_end("rststr");
      push("rststr_memadr", mk(0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
      run(3);
      reset = 1'b1;
      push("rststr_memw_forced", mk(0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      step();
      push("rststr_fetch_held", mk(0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0));
      step();
      reset = 1'b0;
      drive(2'b10, 6'b000000, 4'h0);
      push_front_end("post");
      push("post_branch", mk(0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1));
      push("post_fetch",  mk(1, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0));
      run(4);

      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Op  in  2  instruction bits [27:26] (00 data-processing, 01 memory, 10 branch).
REQ-005 Funct  in  6  instruction bits [25:20] (I, cmd[3:0], S/L).
REQ-006 Rd  in  4  destination register field, instruction bits [15:12].
REQ-007 PCS  out  1  PC-write request to the condition logic.
REQ-008 RegW  out  1  unconditioned register-file write request.
REQ-009 MemW  out  1  unconditioned memory write request.
REQ-010 FlagW  out  2  flag-write request: [1] selects NZ, [0] selects CV.
REQ-011 NoWrite  out  1  suppresses the register write (CMP).
REQ-012 NextPC  out  1  unconditional PC update (fetch).
REQ-013 IRWrite  out  1  instruction register load.
REQ-014 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-015 ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU.
REQ-016 ALUSrcA  out  1  ALU operand A select: 0 = Rn, 1 = PC.
REQ-017 ALUSrcB  out  2  ALU operand B select: 00 = Rm, 01 = ExtImm, 10 = constant 4.
REQ-018 ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-019 ImmSrc  out  2  equals Op.
REQ-020 RegSrc  out  2  [0] = (Op==10), [1] = (Op==01).

Function
REQ-021 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH; every output other than ALUControl, FlagW, NoWrite, ImmSrc, RegSrc and PCS depends only on the state.
REQ-022 State transitions:
- FETCH -> DECODE.
- DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH.
- MEMADR: Funct[0]=1 -> MEMREAD, otherwise MEMWRITE.
- MEMREAD -> MEMWB; EXECUTER and EXECUTEI -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-023 Output values per state; any output not listed is 0:
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-024 ALU decode when ALUOp=1, by Funct[4:1]: 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR, 1010 -> SUB with NoWrite=1; any other value -> ADD.
REQ-025 FlagW SHALL be {Funct[0], Funct[0] & (ALUControl is ADD or SUB)} when ALUOp=1, and 00 otherwise.
REQ-026 When ALUOp=0, ALUControl SHALL be ADD and NoWrite SHALL be 0.
REQ-027 PCS SHALL equal ((Rd==4'hF) & RegW) | Branch.
REQ-028 Instruction latencies, counting FETCH: data-processing 4 cycles; LDR 5; STR 4; branch 3; Op=11 2.

Reset
REQ-029 On a rising edge with reset=1, the state SHALL become FETCH, including when reset arrives mid-instruction.
REQ-030 While reset=1, RegW, MemW, IRWrite, NextPC, Branch and PCS SHALL be forced to 0.

Structure
REQ-031 The state encoding and the ALUControl and ResultSrc/ALUSrcB encodings SHALL be defined in a shared package or header.
REQ-032 The ALU decode SHALL be a combinational sub-module named alu_decoder; next-state logic and output decode SHALL be separate processes.

Verification
REQ-033 Reset held 2 cycles, then Op=00, Funct=001000 (ADD, register): the bench SHALL see FETCH, DECODE, EXECUTER, ALUWB; RegW=1 only in ALUWB; FlagW=00.
REQ-034 Op=01, Funct=011001 (LDR): the bench SHALL see MEMADR, MEMREAD, MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegW=1 in MEMWB.
REQ-035 Op=01, Funct=011000 (STR): the bench SHALL see MemW=1 for exactly one cycle, in MEMWRITE, and a return to FETCH 4 cycles after the start.
REQ-036 Op=00, Funct=110101 (CMP immediate): the bench SHALL see EXECUTEI with ALUControl=01, NoWrite=1 and FlagW=11.
REQ-037 Op=10: the bench SHALL see PCS=1 in BRANCH. Op=00 with Rd=15: the bench SHALL see PCS=1 in ALUWB.
REQ-038 Reset asserted in MEMWRITE: the bench SHALL see MemW=0 immediately and the state at FETCH after the next edge.
